// File: rtl/riscv_imm_pkg.sv
// Immediate format codes shared by the RISC-V immediate encoder and decoder,
// plus the request bundle carried through the encoder's input stage.
package riscv_imm_pkg;

    localparam logic [2:0] IMM_I  = 3'b000;  // I-type, signed 12-bit
    localparam logic [2:0] IMM_IU = 3'b001;  // I-type, unsigned 12-bit
    localparam logic [2:0] IMM_SH = 3'b010;  // shift amount, 5-bit field
    localparam logic [2:0] IMM_S  = 3'b011;  // S-type store offset
    localparam logic [2:0] IMM_B  = 3'b100;  // B-type branch offset
    localparam logic [2:0] IMM_U  = 3'b101;  // U-type upper immediate
    localparam logic [2:0] IMM_J  = 3'b110;  // J-type jump offset

    // Bit groups that must be a pure sign extension for each format
    localparam logic [31:0] MSK_31_11 = 32'hFFFF_F800;
    localparam logic [31:0] MSK_31_12 = 32'hFFFF_F000;
    localparam logic [31:0] MSK_31_20 = 32'hFFF0_0000;
    localparam logic [31:0] MSK_31_4  = 32'hFFFF_FFF0;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  sel;
        logic [31:0] base;
    } imm_req_t;

    // True when every bit selected by mask has the same value
    function automatic logic sext_ok(input logic [31:0] v, input logic [31:0] mask);
        return ((v & mask) == mask) || ((v & mask) == '0);
    endfunction

endpackage

// File: rtl/imm_enc_core.sv
// Combinational immediate scatter into an instruction word plus
// representability check. Out-of-range values still produce the truncated
// encoding; an unknown format passes base through with err set.
module imm_enc_core
    import riscv_imm_pkg::*;
(
    input  logic [31:0] i_imm,
    input  logic [2:0]  i_sel,
    input  logic [31:0] i_base,
    output logic [31:0] o_inst,
    output logic        o_err
);

    // Overlay the immediate fields for the selected format onto base
    always_comb begin
        o_inst = i_base;
        o_err  = 1'b0;
        case (i_sel)
            IMM_I: begin
                o_inst[31:20] = i_imm[11:0];
                o_err         = !sext_ok(i_imm, MSK_31_11);
            end
            IMM_IU: begin
                o_inst[31:20] = i_imm[11:0];
                o_err         = |i_imm[31:12];
            end
            IMM_SH: begin
                o_inst[24:20] = i_imm[4:0];
                o_err         = !sext_ok(i_imm, MSK_31_4);
            end
            IMM_S: begin
                o_inst[31:25] = i_imm[11:5];
                o_inst[11:7]  = i_imm[4:0];
                o_err         = !sext_ok(i_imm, MSK_31_11);
            end
            IMM_B: begin
                o_inst[31]    = i_imm[12];
                o_inst[7]     = i_imm[11];
                o_inst[30:25] = i_imm[10:5];
                o_inst[11:8]  = i_imm[4:1];
                o_err         = i_imm[0] | !sext_ok(i_imm, MSK_31_12);
            end
            IMM_U: begin
                o_inst[31:12] = i_imm[31:12];
                o_err         = |i_imm[11:0];
            end
            IMM_J: begin
                o_inst[31]    = i_imm[20];
                o_inst[30:21] = i_imm[10:1];
                o_inst[20]    = i_imm[11];
                o_inst[19:12] = i_imm[19:12];
                o_err         = i_imm[0] | !sext_ok(i_imm, MSK_31_20);
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_enc.sv
// Two-stage immediate encoder: S1 registers the request, S2 registers the
// encoded instruction. Valid/ready on both sides, full throughput.
// Optional: define IMM_ENC_ERRCNT_EN to add a saturating err_cnt output.
module imm_enc
    import riscv_imm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm,
    input  logic [2:0]  imm_sel,
    input  logic [31:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst,
    output logic        err
`ifdef IMM_ENC_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    logic        r_s1_vld;
    imm_req_t    r_s1_req;
    logic        r_out_vld;
    logic [31:0] r_inst;
    logic        r_err;

    logic        w_s1_load;
    logic        w_s2_load;
    logic [31:0] w_enc_inst;
    logic        w_enc_err;

    // S2 can take a new word when empty or draining this cycle
    assign w_s2_load = r_s1_vld && (!r_out_vld || out_ready);
    assign in_ready  = !r_s1_vld || !r_out_vld || out_ready;
    assign w_s1_load = in_valid && in_ready;

    imm_enc_core u_core (
        .i_imm  (r_s1_req.imm),
        .i_sel  (r_s1_req.sel),
        .i_base (r_s1_req.base),
        .o_inst (w_enc_inst),
        .o_err  (w_enc_err)
    );

    // S1: capture on accept, otherwise empty out when forwarded to S2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld <= 1'b0;
            r_s1_req <= '0;
        end else if (w_s1_load) begin
            r_s1_vld <= 1'b1;
            r_s1_req <= '{imm: imm, sel: imm_sel, base: base};
        end else if (w_s2_load) begin
            r_s1_vld <= 1'b0;
        end
    end

    // S2: load encoded word, hold while stalled, clear on drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld <= 1'b0;
            r_inst    <= '0;
            r_err     <= 1'b0;
        end else if (w_s2_load) begin
            r_out_vld <= 1'b1;
            r_inst    <= w_enc_inst;
            r_err     <= w_enc_err;
        end else if (out_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    assign out_valid = r_out_vld;
    assign inst      = r_inst;
    assign err       = r_err;

`ifdef IMM_ENC_ERRCNT_EN
    logic [15:0] r_err_cnt;

    // Count erroneous results as they leave, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_err_cnt <= '0;
        else if (r_out_vld && out_ready && r_err && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_imm_enc.sv
// Self-checking bench for imm_enc: directed format/latency/stall/reset cases
// and randomized traffic against a field-map reference model with a scoreboard.
// Exercises err_cnt when IMM_ENC_ERRCNT_EN is defined.
module tb_imm_enc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] imm = '0;
    logic [2:0]  imm_sel = '0;
    logic [31:0] base = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] inst;
    logic        err;
`ifdef IMM_ENC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    imm_enc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .imm_sel   (imm_sel),
        .base      (base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst      (inst),
        .err       (err)
`ifdef IMM_ENC_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [32:0] exp_q[$];   // {err, inst} in acceptance order

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: which immediate bit lands in each instruction bit (-1 = base)
    function automatic logic [31:0] model_enc(input logic [31:0] v, input logic [2:0] sel,
                                              input logic [31:0] b);
        int map[32];
        logic [31:0] r;
        for (int i = 0; i < 32; i++) map[i] = -1;
        case (sel)
            3'd0, 3'd1: for (int i = 20; i <= 31; i++) map[i] = i - 20;
            3'd2: for (int i = 20; i <= 24; i++) map[i] = i - 20;
            3'd3: begin
                for (int i = 25; i <= 31; i++) map[i] = i - 20;
                for (int i = 7; i <= 11; i++) map[i] = i - 7;
            end
            3'd4: begin
                map[31] = 12; map[7] = 11;
                for (int i = 25; i <= 30; i++) map[i] = i - 20;
                for (int i = 8; i <= 11; i++) map[i] = i - 7;
            end
            3'd5: for (int i = 12; i <= 31; i++) map[i] = i;
            3'd6: begin
                map[31] = 20; map[20] = 11;
                for (int i = 21; i <= 30; i++) map[i] = i - 20;
                for (int i = 12; i <= 19; i++) map[i] = i;
            end
            default: ;
        endcase
        r = b;
        for (int i = 0; i < 32; i++) if (map[i] >= 0) r[i] = v[map[i]];
        return r;
    endfunction

    // Reference: representable ranges expressed as signed/unsigned intervals
    function automatic logic model_err(input logic [31:0] v, input logic [2:0] sel);
        longint s;
        s = longint'($signed(v));
        case (sel)
            3'd0, 3'd3: return !(s >= -2048 && s <= 2047);
            3'd1:       return v >= 32'd4096;
            3'd2:       return !(s >= -16 && s <= 15);
            3'd4:       return v[0] || !(s >= -4096 && s <= 4095);
            3'd5:       return (v % 32'd4096) != 0;
            3'd6:       return v[0] || !(s >= -64'sd1048576 && s <= 64'sd1048575);
            default:    return 1'b1;
        endcase
    endfunction

    // One cycle: called in the low phase, drives inputs, scores handshakes
    // of the coming rising edge, returns at the next falling edge.
    task automatic step(input logic v, input logic [31:0] i_imm, input logic [2:0] sel,
                        input logic [31:0] b, input logic ordy, output logic acc);
        logic [32:0] e;
        in_valid = v; imm = i_imm; imm_sel = sel; base = b; out_ready = ordy;
        #1;
        acc = v && in_ready;
        if (out_valid && out_ready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_inst", inst, e[31:0]);
                chk("sb_err", 32'(err), 32'(e[32]));
            end
        end
        if (acc) exp_q.push_back({model_err(i_imm, sel), model_enc(i_imm, sel, b)});
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef IMM_ENC_ERRCNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic single(input string tag, input logic [31:0] i_imm, input logic [2:0] sel,
                          input logic [31:0] b, input logic [31:0] x_inst, input logic x_err);
        logic acc;
        step(1'b1, i_imm, sel, b, 1'b1, acc);
        chk({tag, "_acc"}, 32'(acc), 32'd1);
        #1 chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step(1'b0, '0, '0, '0, 1'b1, acc);
        #1;
        chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
        chk({tag, "_inst"}, inst, x_inst);
        chk({tag, "_err"}, 32'(err), 32'(x_err));
        step(1'b0, '0, '0, '0, 1'b1, acc);
    endtask

    task automatic drain(input string tag);
        logic acc;
        for (int k = 0; k < 50 && (exp_q.size() != 0 || out_valid); k++)
            step(1'b0, '0, '0, '0, 1'b1, acc);
        chk(tag, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [31:0] rnd_imm();
        case ($urandom % 5)
            0: return $urandom;
            1: return 32'($urandom_range(0, 4095)) - 32'd2048;
            2: return 32'($urandom_range(0, 31)) - 32'd16;
            3: return {$urandom, 12'h000} | 32'($urandom % 2);
            default: return 32'($urandom_range(0, 2097151)) - 32'd1048576;
        endcase
    endfunction

    initial begin
        logic acc;
        logic [31:0] s_imm[3];
        logic [2:0]  s_sel[3];
        logic [31:0] s_base[3];
        logic [31:0] held;
        logic        have_held;
        int          idx;

        @(negedge clk);
        do_reset();

        // Directed format cases with hand-derived results
        single("i_neg",  32'hFFFFF800, 3'b000, 32'h00000013, 32'h80000013, 1'b0);
        single("b_max",  32'h00000FFE, 3'b100, 32'h00000063, 32'h7E000FE3, 1'b0);
        single("b_ovf",  32'h00001000, 3'b100, 32'h00000063, 32'h80000063, 1'b1);
        single("u_ok",   32'h12345000, 3'b101, 32'h00000037, 32'h12345037, 1'b0);
        single("u_low",  32'h12345001, 3'b101, 32'h00000037, 32'h12345037, 1'b1);
        single("j_odd",  32'h00000001, 3'b110, 32'h00000037, 32'h00000037, 1'b1);
        single("sel7",   32'h00000000, 3'b111, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);

        // Back-pressure: three requests offered during a 5-cycle stall
        for (int k = 0; k < 3; k++) begin
            s_imm[k] = rnd_imm(); s_sel[k] = 3'($urandom % 8); s_base[k] = $urandom;
        end
        idx = 0; have_held = 1'b0; held = '0;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, s_imm[idx], s_sel[idx], s_base[idx], 1'b0, acc);
            if (acc) idx++;
            if (out_valid) begin
                if (have_held) chk("stall_stable", inst, held);
                held = inst; have_held = 1'b1;
            end
        end
        #1;
        chk("stall_accepted", 32'(idx), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        chk("stall_first", inst, model_enc(s_imm[0], s_sel[0], s_base[0]));
        for (int k = 0; k < 20 && idx < 3; k++) begin
            step(1'b1, s_imm[idx], s_sel[idx], s_base[idx], 1'b1, acc);
            if (acc) idx++;
        end
        chk("stall_all_accepted", 32'(idx), 32'd3);
        drain("stall_drain");

        // Reset while a result is waiting at the output
        step(1'b1, 32'h00000123, 3'b000, 32'h00000013, 1'b0, acc);
        step(1'b0, '0, '0, '0, 1'b0, acc);
        #1 chk("pre_rst_valid", 32'(out_valid), 32'd1);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(1'b0, '0, '0, '0, 1'b1, acc);
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random back-pressure
        for (int k = 0; k < 600; k++)
            step(($urandom % 4) != 0, rnd_imm(), 3'($urandom % 8), $urandom,
                 ($urandom % 4) != 0, acc);
        drain("rand_drain");

`ifdef IMM_ENC_ERRCNT_EN
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, $urandom, 3'b111, $urandom, 1'b1, acc);
        step(1'b1, 32'h5, 3'b000, 32'h13, 1'b1, acc);
        drain("cnt_drain");
        chk("err_cnt_3", 32'(err_cnt), 32'd3);
        dut.r_err_cnt = 16'hFFFD;
        for (int k = 0; k < 5; k++) step(1'b1, $urandom, 3'b111, $urandom, 1'b1, acc);
        drain("sat_drain");
        chk("err_cnt_sat", 32'(err_cnt), 32'h0000FFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
